// File: rtl/i2c_txn_sequencer.sv
// Transaction sequencer for the byte-oriented I2C master engine: expands one
// address/direction/length request into START+address, data, ACK/NACK and STOP commands.
module i2c_txn_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [6:0] req_addr,
   input  logic       req_read,
   input  logic [7:0] req_len,
   input  logic [7:0] wr_data,
   input  logic       wr_valid,
   output logic       wr_ready,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   input  logic       rd_ready,
   output logic       busy,
   output logic       done,
   output logic       err_nack,
   output logic       err_timeout,
   output logic       eng_valid,
   input  logic       eng_ready,
   output logic       eng_byte,
   output logic       eng_start,
   output logic       eng_stop,
   output logic       eng_read,
   output logic       eng_ack_out,
   output logic [7:0] eng_tx,
   input  logic       eng_done,
   input  logic [7:0] eng_rx,
   input  logic       eng_nack
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_WFETCH,
      S_RHOLD,
      S_STOP,
      S_DONE
   } state_t;

   // Timeout fires when the incremented counter would reach TIMEOUT_CYCLES-1,
   // so done lands exactly TIMEOUT_CYCLES cycles after the handshake.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 2);

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  remaining;
   logic [15:0] tcnt;
   logic        req_is_read;

   logic accept;
   logic eng_hs;
   logic load_wr;
   logic load_rd;
   logic load_stop;
   logic set_nack;
   logic set_timeout;
   logic cap_rd;

   assign req_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign wr_ready  = (state == S_WFETCH);
   assign rd_valid  = (state == S_RHOLD);
   assign eng_valid = (state == S_ISSUE) || (state == S_STOP);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= S_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register
         // updates from pre-edge values regardless of statement order.
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: every signal written here gets a default first so no path through
      // the case infers a latch.
      state_nxt   = state;
      accept      = 1'b0;
      eng_hs      = 1'b0;
      load_wr     = 1'b0;
      load_rd     = 1'b0;
      load_stop   = 1'b0;
      set_nack    = 1'b0;
      set_timeout = 1'b0;
      cap_rd      = 1'b0;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               accept    = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE, S_STOP: begin
            if (eng_ready) begin
               eng_hs    = 1'b1;
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (eng_done) begin
               if (!eng_byte) begin
                  state_nxt = S_DONE;
               end else if (eng_read) begin
                  cap_rd    = 1'b1;
                  state_nxt = S_RHOLD;
               end else if (eng_nack) begin
                  set_nack  = 1'b1;
                  load_stop = !eng_stop;
                  state_nxt = eng_stop ? S_DONE : S_STOP;
               end else if (remaining == 8'd0) begin
                  state_nxt = S_DONE;
               end else if (req_is_read) begin
                  load_rd   = 1'b1;
                  state_nxt = S_ISSUE;
               end else begin
                  state_nxt = S_WFETCH;
               end
            end else if (tcnt == TO_LAST) begin
               // No STOP after a timeout: the engine owns bus recovery.
               set_timeout = 1'b1;
               state_nxt   = S_DONE;
            end
         end
         S_WFETCH: begin
            if (wr_valid) begin
               load_wr   = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_RHOLD: begin
            if (rd_ready) begin
               if (remaining == 8'd0) begin
                  state_nxt = S_DONE;
               end else begin
                  load_rd   = 1'b1;
                  state_nxt = S_ISSUE;
               end
            end
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         remaining   <= 8'd0;
         req_is_read <= 1'b0;
         tcnt        <= 16'd0;
         eng_tx      <= 8'd0;
         eng_byte    <= 1'b0;
         eng_start   <= 1'b0;
         eng_stop    <= 1'b0;
         eng_read    <= 1'b0;
         eng_ack_out <= 1'b0;
         rd_data     <= 8'd0;
         err_nack    <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         if (accept) begin
            remaining   <= req_len;
            req_is_read <= req_read;
            eng_tx      <= {req_addr, req_read};
            eng_byte    <= 1'b1;
            eng_start   <= 1'b1;
            eng_stop    <= (req_len == 8'd0);
            eng_read    <= 1'b0;
            eng_ack_out <= 1'b0;
            err_nack    <= 1'b0;
            err_timeout <= 1'b0;
         end
         if (load_wr || load_rd) begin
            eng_byte    <= 1'b1;
            eng_start   <= 1'b0;
            eng_stop    <= (remaining == 8'd1);
            eng_read    <= load_rd;
            eng_ack_out <= load_rd && (remaining != 8'd1);
            if (remaining != 8'd0) begin
               remaining <= remaining - 8'd1;
            end
         end
         if (load_wr) begin
            eng_tx <= wr_data;
         end
         if (load_stop) begin
            eng_byte    <= 1'b0;
            eng_start   <= 1'b0;
            eng_stop    <= 1'b1;
            eng_read    <= 1'b0;
            eng_ack_out <= 1'b0;
         end
         if (eng_hs) begin
            tcnt <= 16'd0;
         end else if (state == S_WAIT) begin
            tcnt <= tcnt + 16'd1;
         end
         if (cap_rd) begin
            rd_data <= eng_rx;
         end
         if (set_nack) begin
            err_nack <= 1'b1;
         end
         if (set_timeout) begin
            err_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Scoreboard bench for i2c_txn_sequencer: directed transactions push expected engine
// commands, read beats and done flags; a monitor pops and compares as the DUT presents them.
module tb_i2c_txn_sequencer;

   logic       clk;
   logic       rstn;
   logic       req_valid;
   logic       req_ready;
   logic [6:0] req_addr;
   logic       req_read;
   logic [7:0] req_len;
   logic [7:0] wr_data;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       rd_ready;
   logic       busy;
   logic       done;
   logic       err_nack;
   logic       err_timeout;
   logic       eng_valid;
   logic       eng_ready;
   logic       eng_byte;
   logic       eng_start;
   logic       eng_stop;
   logic       eng_read;
   logic       eng_ack_out;
   logic [7:0] eng_tx;
   logic       eng_done;
   logic [7:0] eng_rx;
   logic       eng_nack;

   typedef struct packed {
      logic       b;
      logic       st;
      logic       sp;
      logic       rd;
      logic       ack;
      logic [7:0] tx;
   } cmd_t;

   typedef struct {
      logic nack;
      logic tmo;
      int   kind;   // 0: no timing check, 1: cycles after handshake, 2: cycles after eng_done
      int   delta;
   } exp_done_t;

   cmd_t       exp_cmd_q[$];
   logic [7:0] exp_rd_q[$];
   exp_done_t  exp_done_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] wr_q[$];

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   int   wr_hs_cnt = 0;
   int   last_hs_cyc = 0;
   int   last_edone_cyc = 0;
   logic eng_mute = 1'b0;
   logic nack_addr = 1'b0;

   i2c_txn_sequencer #(.TIMEOUT_CYCLES(100)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_read(req_read), .req_len(req_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .busy(busy), .done(done), .err_nack(err_nack), .err_timeout(err_timeout),
      .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_byte(eng_byte),
      .eng_start(eng_start), .eng_stop(eng_stop), .eng_read(eng_read),
      .eng_ack_out(eng_ack_out), .eng_tx(eng_tx), .eng_done(eng_done),
      .eng_rx(eng_rx), .eng_nack(eng_nack)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic cmd_t mk_cmd(input logic b, input logic st, input logic sp,
                                   input logic rd, input logic ack, input logic [7:0] tx);
      cmd_t c;
      c = '{b: b, st: st, sp: sp, rd: rd, ack: ack, tx: tx};
      return c;
   endfunction

   function automatic exp_done_t mk_done(input logic n, input logic t, input int k, input int d);
      exp_done_t e;
      e.nack = n; e.tmo = t; e.kind = k; e.delta = d;
      return e;
   endfunction

   // Engine model: answers each accepted command two cycles later unless muted.
   initial begin
      logic c_read;
      logic c_addr;
      eng_done = 1'b0; eng_rx = 8'h00; eng_nack = 1'b0;
      forever begin
         @(negedge clk);
         if (rstn && eng_valid && eng_ready && !eng_mute) begin
            c_read = eng_read;
            c_addr = eng_start;
            repeat (2) @(posedge clk);
            #1;
            eng_done = 1'b1;
            eng_rx   = 8'h00;
            if (c_read && rx_q.size() != 0) eng_rx = rx_q.pop_front();
            eng_nack = c_addr && nack_addr;
            @(posedge clk);
            #1;
            eng_done = 1'b0; eng_nack = 1'b0; eng_rx = 8'h00;
         end
      end
   end

   // Write-data source: presents the head of wr_q, pops it after a handshake.
   initial begin
      logic hs;
      wr_valid = 1'b0; wr_data = 8'h00;
      forever begin
         @(negedge clk);
         hs = wr_valid && wr_ready;
         @(posedge clk);
         #1;
         if (hs && wr_q.size() != 0) void'(wr_q.pop_front());
         wr_valid = (wr_q.size() != 0);
         wr_data  = wr_valid ? wr_q[0] : 8'h00;
      end
   end

   // Monitor / scoreboard.
   initial begin
      cmd_t      e;
      exp_done_t ed;
      logic      rd_prev = 1'b0;
      logic      wr_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rstn) begin
            if (eng_done) last_edone_cyc = cyc;
            if (eng_valid && eng_ready) begin
               last_hs_cyc = cyc;
               check("cmd expected", 32'(exp_cmd_q.size() != 0), 32'd1);
               if (exp_cmd_q.size() != 0) begin
                  e = exp_cmd_q.pop_front();
                  check("cmd byte/start/stop/read", 32'({eng_byte, eng_start, eng_stop, eng_read}),
                        32'({e.b, e.st, e.sp, e.rd}));
                  if (e.rd) check("cmd ack_out", 32'(eng_ack_out), 32'(e.ack));
                  if (e.b && !e.rd) check("cmd tx", 32'(eng_tx), 32'(e.tx));
               end
            end
            if (rd_valid) check("no command while rd_valid", 32'(eng_valid), 32'd0);
            if (rd_valid && !rd_prev) check("rd_valid latency", 32'(cyc - last_edone_cyc), 32'd1);
            if (wr_ready && !wr_prev) check("wr_ready latency", 32'(cyc - last_edone_cyc), 32'd1);
            if (rd_valid && rd_ready) begin
               check("rd beat expected", 32'(exp_rd_q.size() != 0), 32'd1);
               if (exp_rd_q.size() != 0) check("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
            end
            if (wr_valid && wr_ready) wr_hs_cnt++;
            if (done) begin
               done_cnt++;
               check("busy with done", 32'(busy), 32'd1);
               check("done expected", 32'(exp_done_q.size() != 0), 32'd1);
               if (exp_done_q.size() != 0) begin
                  ed = exp_done_q.pop_front();
                  check("err_nack", 32'(err_nack), 32'(ed.nack));
                  check("err_timeout", 32'(err_timeout), 32'(ed.tmo));
                  if (ed.kind == 1) check("done after handshake", 32'(cyc - last_hs_cyc), 32'(ed.delta));
                  if (ed.kind == 2) check("done after eng_done", 32'(cyc - last_edone_cyc), 32'(ed.delta));
               end
            end
         end
         rd_prev = rd_valid;
         wr_prev = wr_ready;
      end
   end

   task automatic check_idle(input string name);
      check({name, " req_ready"}, 32'(req_ready), 32'd1);
      check({name, " outputs zero"},
            32'({busy, done, err_nack, err_timeout, eng_valid, eng_byte, eng_start, eng_stop,
                 eng_read, eng_ack_out, wr_ready, rd_valid}), 32'd0);
      check({name, " data zero"}, 32'({eng_tx, rd_data}), 32'd0);
   endtask

   task automatic issue_req(input logic [6:0] a, input logic rd, input logic [7:0] len);
      bit ok = 1'b0;
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_addr = a; req_read = rd; req_len = len;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (req_ready) ok = 1'b1;
      end
      check("request accepted", 32'(ok), 32'd1);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("eng_valid one cycle after accept", 32'(eng_valid), 32'd1);
   endtask

   task automatic wait_done(input int budget, input string name);
      int  start = done_cnt;
      bit  ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(posedge clk);
         if (done_cnt != start) ok = 1'b1;
      end
      check({name, " done seen"}, 32'(ok), 32'd1);
   endtask

   task automatic wait_rd(input int budget, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         if (rd_valid) ok = 1'b1;
      end
      check({name, " rd_valid seen"}, 32'(ok), 32'd1);
   endtask

   initial begin
      int hs0;
      rstn = 1'b0; req_valid = 1'b0; req_addr = 7'h00; req_read = 1'b0; req_len = 8'h00;
      rd_ready = 1'b1; eng_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      rstn = 1'b1;

      // Write 0x55, two bytes
      hs0 = wr_hs_cnt;
      wr_q = '{8'h11, 8'h22};
      exp_cmd_q.push_back(mk_cmd(1, 1, 0, 0, 0, 8'hAA));
      exp_cmd_q.push_back(mk_cmd(1, 0, 0, 0, 0, 8'h11));
      exp_cmd_q.push_back(mk_cmd(1, 0, 1, 0, 0, 8'h22));
      exp_done_q.push_back(mk_done(0, 0, 0, 0));
      issue_req(7'h55, 1'b0, 8'd2);
      wait_done(200, "write");
      check("write wr handshakes", 32'(wr_hs_cnt - hs0), 32'd2);

      // Read 0x50, three bytes
      rx_q = '{8'h01, 8'h02, 8'h03};
      exp_cmd_q.push_back(mk_cmd(1, 1, 0, 0, 0, 8'hA1));
      exp_cmd_q.push_back(mk_cmd(1, 0, 0, 1, 1, 8'h00));
      exp_cmd_q.push_back(mk_cmd(1, 0, 0, 1, 1, 8'h00));
      exp_cmd_q.push_back(mk_cmd(1, 0, 1, 1, 0, 8'h00));
      exp_rd_q = '{8'h01, 8'h02, 8'h03};
      exp_done_q.push_back(mk_done(0, 0, 0, 0));
      issue_req(7'h50, 1'b1, 8'd3);
      wait_done(200, "read");

      // Address NACK on a two-byte write: STOP only, no data fetched
      hs0 = wr_hs_cnt;
      nack_addr = 1'b1;
      wr_q = '{8'hDE, 8'hAD};
      exp_cmd_q.push_back(mk_cmd(1, 1, 0, 0, 0, 8'h54));
      exp_cmd_q.push_back(mk_cmd(0, 0, 1, 0, 0, 8'h00));
      exp_done_q.push_back(mk_done(1, 0, 0, 0));
      issue_req(7'h2A, 1'b0, 8'd2);
      wait_done(200, "nack");
      check("nack wr handshakes", 32'(wr_hs_cnt - hs0), 32'd0);
      nack_addr = 1'b0;
      wr_q.delete();

      // Address-only probe
      exp_cmd_q.push_back(mk_cmd(1, 1, 1, 0, 0, 8'h78));
      exp_done_q.push_back(mk_done(0, 0, 2, 1));
      issue_req(7'h3C, 1'b0, 8'd0);
      wait_done(200, "probe");

      // Timeout: engine never answers
      eng_mute = 1'b1;
      exp_cmd_q.push_back(mk_cmd(1, 1, 0, 0, 0, 8'h20));
      exp_done_q.push_back(mk_done(0, 1, 1, 100));
      issue_req(7'h10, 1'b0, 8'd1);
      wait_done(200, "timeout");
      eng_mute = 1'b0;

      // Next request after timeout is accepted and clears the flag
      exp_cmd_q.push_back(mk_cmd(1, 1, 1, 0, 0, 8'h02));
      exp_done_q.push_back(mk_done(0, 0, 2, 1));
      issue_req(7'h01, 1'b0, 8'd0);
      wait_done(200, "post-timeout probe");

      // Read backpressure, then reset while the second beat is held
      @(posedge clk);
      #1;
      rd_ready = 1'b0;
      rx_q = '{8'h5A, 8'hC3};
      exp_cmd_q.push_back(mk_cmd(1, 1, 0, 0, 0, 8'h67));
      exp_cmd_q.push_back(mk_cmd(1, 0, 0, 1, 1, 8'h00));
      exp_cmd_q.push_back(mk_cmd(1, 0, 1, 1, 0, 8'h00));
      exp_rd_q.push_back(8'h5A);
      issue_req(7'h33, 1'b1, 8'd2);
      wait_rd(100, "backpressure first");
      repeat (10) @(posedge clk);
      #1;
      rd_ready = 1'b1;
      @(posedge clk);
      #1;
      rd_ready = 1'b0;
      wait_rd(100, "backpressure second");
      #2;
      rstn = 1'b0;
      #1;
      check_idle("reset in RHOLD");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      rd_ready = 1'b1;

      // Reset while a command is pending: eng_valid drops without a clock edge
      eng_ready = 1'b0;
      issue_req(7'h7F, 1'b0, 8'd1);
      #2;
      rstn = 1'b0;
      #1;
      check_idle("reset in ISSUE");
      @(posedge clk);
      #1;
      rstn = 1'b1;
      eng_ready = 1'b1;
      repeat (3) @(posedge clk);

      check("cmd queue drained", 32'(exp_cmd_q.size()), 32'd0);
      check("rd queue drained", 32'(exp_rd_q.size()), 32'd0);
      check("done queue drained", 32'(exp_done_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_txn_sequencer.md
# i2c_txn_sequencer

Transaction-level sequencer for the SoC's byte-oriented I2C master engine (`simple_i2c` in master mode). It accepts one request at a time: a 7-bit address, a direction and a byte count. It expands the request into the engine's per-byte command sequence: START plus address byte, data bytes, master ACK/NACK, and STOP. Write data is streamed in, read data is streamed out, and NACK and timeout errors are reported. It sits between the I2C register front end and the byte engine.

## Interface

Parameters:

- `TIMEOUT_CYCLES`, default 65535: cycles allowed between command acceptance and `eng_done`. Legal range 2..65535.

Ports:

- `clk`  in  1  system clock; all logic on its rising edge
- `rstn`  in  1  reset; asynchronous, active-low
- `req_valid`  in  1  transaction request
- `req_ready`  out  1  high only in IDLE
- `req_addr`  in  7  slave address
- `req_read`  in  1  1 = read, 0 = write
- `req_len`  in  8  data byte count; 0 = address-only probe
- `wr_data`  in  8  write byte
- `wr_valid`  in  1  write byte valid
- `wr_ready`  out  1  sequencer takes a write byte
- `rd_data`  out  8  read byte
- `rd_valid`  out  1  read byte valid
- `rd_ready`  in  1  consumer takes the read byte
- `busy`  out  1  not IDLE
- `done`  out  1  one-cycle pulse at end of transaction
- `err_nack`  out  1  slave NACKed; valid with `done`, held until next `done`
- `err_timeout`  out  1  engine timeout; valid with `done`, held until next `done`
- `eng_valid`  out  1  command to engine
- `eng_ready`  in  1  engine accepts command
- `eng_byte`  out  1  1 = transfer a byte; 0 = condition only (STOP)
- `eng_start`  out  1  generate START before the byte
- `eng_stop`  out  1  generate STOP after the byte, or alone when `eng_byte`=0
- `eng_read`  out  1  byte is a read
- `eng_ack_out`  out  1  master ACK after a read byte (0 = NACK)
- `eng_tx`  out  8  byte to send
- `eng_done`  in  1  one-cycle pulse: command finished
- `eng_rx`  in  8  received byte; valid with `eng_done`
- `eng_nack`  in  1  slave NACK on a written byte; valid with `eng_done`

## Operation

- **States:** IDLE, ISSUE, WAIT, WFETCH, RHOLD, STOP, DONE.
- **IDLE:** on `req_valid`, latch the request.
  - Set `remaining` = `req_len`.
  - Load the command register as: `eng_tx`={addr,read}, start=1, byte=1, read=0, stop=(len==0).
  - Go to ISSUE.
- **ISSUE:** assert `eng_valid`; command fields are stable until `eng_ready`. On handshake, clear the timeout counter and go to WAIT.
- **WAIT:** increment the timeout counter each cycle.
  - If the counter reaches `TIMEOUT_CYCLES - 1` with no `eng_done`: set `err_timeout` and go to DONE. No STOP is issued.
  - On `eng_done` for the address byte or a write byte:
    - If `eng_nack` and the command had stop=1: set `err_nack`, go to DONE.
    - If `eng_nack` and stop=0: set `err_nack`, go to STOP.
    - Otherwise, if `remaining`==0: go to DONE.
    - Otherwise, for a write: go to WFETCH.
    - Otherwise, for a read: load a read command (read=1, byte=1, ack_out=(remaining!=1), stop=(remaining==1)), decrement `remaining`, go to ISSUE.
  - On `eng_done` for a read byte: capture `eng_rx` into `rd_data`, go to RHOLD. `eng_nack` is ignored for reads.
- **WFETCH:** `wr_ready`=1. On `wr_valid`, load `eng_tx`=`wr_data` with stop=(remaining==1), decrement `remaining`, go to ISSUE. A stall here is unbounded.
- **RHOLD:** `rd_valid`=1.
  - On `rd_ready` with `remaining`==0: go to DONE.
  - On `rd_ready` otherwise: load the next read command and go to ISSUE.
- **STOP:** issue a command with byte=0, stop=1. Then go to WAIT; its `eng_done` goes to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE. Error flags are cleared on the next request acceptance.
- **Remaining counter:** 8-bit, never decremented below 0. `req_len`=255 is legal.

## Timing

- **Reset values:** state=IDLE; `req_ready`=1 while `rstn` is low. All other outputs are 0, including `rd_data`, `eng_tx`, `err_*`.
- **Reset mid-transaction:** immediate return to IDLE. `eng_valid` drops asynchronously. Bus recovery belongs to the engine.
- **Latency:**
  - Request accepted in cycle 0 gives `eng_valid` in cycle 1.
  - `eng_done` in cycle n gives the next `eng_valid` at n+1 for reads, or WFETCH at n+1 for writes.
  - `eng_done` in cycle n gives `rd_valid` at n+1.
- **Ordering:**
  - `wr_ready` is asserted only in WFETCH, exactly once per data byte.
  - `rd_valid` is held until `rd_ready`.
  - No engine command is issued while `rd_valid` is high.
- **Events while not waiting:** `eng_done` outside WAIT is ignored. A simultaneous `eng_done` and timeout expiry resolves to `eng_done`.
- **`busy`:** equals (state != IDLE). `done` coincides with the last `busy` cycle.

## Test plan

- **Write:** `req` addr=0x55, write, len=2, data 0x11, 0x22.
  - Engine receives 0xAA(start), 0x11, 0x22(stop).
  - `done` with `err_nack`=0 and `err_timeout`=0; `wr_ready` handshakes = 2.
- **Read:** addr=0x50, read, len=3, engine returns 0x01, 0x02, 0x03.
  - Engine receives 0xA1(start), then 3 reads with ack_out 1, 1, 0; stop on the third.
  - `rd_data` beats 0x01, 0x02, 0x03.
- **Address NACK:** write, len=2, `eng_nack`=1 on the address byte.
  - Next command is byte=0, stop=1.
  - `done` with `err_nack`=1; `wr_ready` never asserted.
- **Probe:** addr=0x3C, len=0.
  - Single command 0x78 with start=1, stop=1.
  - `done` 1 cycle after its `eng_done`.
- **Timeout:** `TIMEOUT_CYCLES`=100, `eng_done` never pulsed.
  - `done` with `err_timeout`=1 exactly 100 cycles after the handshake.
  - `eng_valid` stays 0; the next request is accepted.
- **Backpressure and reset:** read, len=2, `rd_ready` held low 10 cycles.
  - `eng_valid` stays 0 until the first `rd_ready`.
  - `rstn` pulsed low mid-transfer forces IDLE and `req_ready`=1 with all outputs 0.
